// File: rtl/module_antirrebote.sv
// Push-button debouncer: 2-flop synchronizer followed by a four-state
// qualification FSM. A level change is accepted only after the synchronized
// input holds the new value for N_CICLOS consecutive cycles. The registered
// outputs are the debounced level and one-cycle press/release pulses.
module module_antirrebote #(
  parameter int unsigned N_CICLOS = 10000
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic boton_i,
  output logic boton_o,
  output logic pulso_o,
  output logic pulso_suelta_o
);

  localparam int unsigned CW = $clog2(N_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_CICLOS - 1);

  typedef enum logic [1:0] {
    REPOSO,
    CONFIRMA_ALTO,
    PRESIONADO,
    CONFIRMA_BAJO
  } estado_t;

  estado_t       estado, estado_sig;
  logic [CW-1:0] cnt, cnt_sig;
  logic          sync_1, s;
  logic          boton_sig, pulso_sig, suelta_sig;

  // Synchronizer, state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      sync_1         <= 1'b0;
      s              <= 1'b0;
      estado         <= REPOSO;
      cnt            <= '0;
      boton_o        <= 1'b0;
      pulso_o        <= 1'b0;
      pulso_suelta_o <= 1'b0;
    end else begin
      sync_1         <= boton_i;
      s              <= sync_1;
      estado         <= estado_sig;
      cnt            <= cnt_sig;
      boton_o        <= boton_sig;
      pulso_o        <= pulso_sig;
      pulso_suelta_o <= suelta_sig;
    end
  end

  // Next state and qualification counter; cnt stays within 0..N_CICLOS-1
  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    unique case (estado)
      REPOSO: begin
        if (s) begin
          estado_sig = CONFIRMA_ALTO;
          cnt_sig    = CW'(1);
        end else begin
          cnt_sig = '0;
        end
      end
      CONFIRMA_ALTO: begin
        if (!s) begin
          estado_sig = REPOSO;
          cnt_sig    = '0;
        end else if (cnt == CNT_MAX) begin
          estado_sig = PRESIONADO;
          cnt_sig    = '0;
        end else begin
          cnt_sig = cnt + 1'b1;
        end
      end
      PRESIONADO: begin
        if (!s) begin
          estado_sig = CONFIRMA_BAJO;
          cnt_sig    = CW'(1);
        end else begin
          cnt_sig = '0;
        end
      end
      CONFIRMA_BAJO: begin
        if (s) begin
          estado_sig = PRESIONADO;
          cnt_sig    = '0;
        end else if (cnt == CNT_MAX) begin
          estado_sig = REPOSO;
          cnt_sig    = '0;
        end else begin
          cnt_sig = cnt + 1'b1;
        end
      end
      default: begin
        estado_sig = REPOSO;
        cnt_sig    = '0;
      end
    endcase
  end

  // Output values computed from the upcoming state so the registered
  // outputs change on the same edge as the accepting transition
  always_comb begin
    boton_sig  = (estado_sig == PRESIONADO) || (estado_sig == CONFIRMA_BAJO);
    pulso_sig  = (estado == CONFIRMA_ALTO) && (estado_sig == PRESIONADO);
    suelta_sig = (estado == CONFIRMA_BAJO) && (estado_sig == REPOSO);
  end

endmodule
